instr_encoder: RTL and testbench

Packs decoded instruction fields (opcode, funct3, registers, 32-bit immediate) into RV32I instruction words, scattering each immediate into I/S/B/U/J bit positions. It is the inverse of the core's immediate generator and is used by the boot/self-test sequencer to build instruction streams for instruction memory. It also expands a load-immediate (LI) pseudo-op into a LUI+ADDI pair. Input and output each use a valid/ready handshake, with a one-entry registered output.

---
 rtl/instr_encoder.sv | 155 +++++++++++++++
 tb/tb_instr_encoder.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder.sv
// Packs decoded fields into RV32I words and expands LI into LUI/ADDI. Output is valid one cycle after accept.
// When the output is stalled, the beat is held and in_ready drops. A two-beat LI also blocks input until its second beat is loaded.
module instr_encoder (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  fmt,
    input  logic [6:0]  opcode,
    input  logic [2:0]  funct3,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [31:0] imm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic        out_err,
    output logic        out_last
);

    typedef enum logic {IDLE, SECOND} state_t;

    localparam logic [2:0] FMT_I  = 3'd0;
    localparam logic [2:0] FMT_S  = 3'd1;
    localparam logic [2:0] FMT_B  = 3'd2;
    localparam logic [2:0] FMT_U  = 3'd3;
    localparam logic [2:0] FMT_J  = 3'd4;
    localparam logic [2:0] FMT_LI = 3'd5;
    localparam logic [6:0] OP_LUI  = 7'h37;
    localparam logic [6:0] OP_ADDI = 7'h13;

    state_t      state, state_nxt;
    logic [31:0] pend_q, pend_nxt;
    logic        out_valid_nxt, err_nxt, last_nxt;
    logic [31:0] instr_nxt;
    logic        ready_int, accept;

    logic [31:0] enc_word;
    logic        enc_err, enc_two;
    logic [11:0] li_lo;
    logic [19:0] li_hi;
    logic [31:0] li_lui, li_addi_x0, li_addi_rd;
    logic        i_ok, b_ok, j_ok, u_ok;

    always_comb begin
        i_ok = (imm[31:11] == {21{imm[31]}});
        b_ok = (imm[31:12] == {20{imm[31]}}) && !imm[0];
        j_ok = (imm[31:20] == {12{imm[31]}}) && !imm[0];
        u_ok = (imm[11:0] == 12'd0);

        // ADDI sign-extends lo, so hi absorbs the carry when lo is negative.
        li_lo      = imm[11:0];
        li_hi      = imm[31:12] + {19'd0, imm[11]};
        li_lui     = {li_hi, rd, OP_LUI};
        li_addi_x0 = {li_lo, 5'd0, 3'd0, rd, OP_ADDI};
        li_addi_rd = {li_lo, rd, 3'd0, rd, OP_ADDI};

        enc_word = 32'd0;
        enc_err  = 1'b0;
        enc_two  = 1'b0;
        case (fmt)
            FMT_I: begin
                enc_word = {imm[11:0], rs1, funct3, rd, opcode};
                enc_err  = !i_ok;
            end
            FMT_S: begin
                enc_word = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
                enc_err  = !i_ok;
            end
            FMT_B: begin
                enc_word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
                enc_err  = !b_ok;
            end
            FMT_U: begin
                enc_word = {imm[31:12], rd, opcode};
                enc_err  = !u_ok;
            end
            FMT_J: begin
                enc_word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
                enc_err  = !j_ok;
            end
            FMT_LI: begin
                if (li_hi == 20'd0) begin
                    enc_word = li_addi_x0;
                end else if (li_lo == 12'd0) begin
                    enc_word = li_lui;
                end else begin
                    enc_word = li_lui;
                    enc_two  = 1'b1;
                end
            end
            default: begin
                enc_word = 32'd0;
                enc_err  = 1'b1;
            end
        endcase
    end

    assign ready_int = (state == IDLE) && (!out_valid || out_ready);
    assign accept    = in_valid && ready_int;
    assign in_ready  = rst_n && ready_int;

    always_comb begin
        state_nxt     = state;
        pend_nxt      = pend_q;
        out_valid_nxt = out_valid;
        instr_nxt     = out_instr;
        err_nxt       = out_err;
        last_nxt      = out_last;
        case (state)
            IDLE: begin
                if (accept) begin
                    out_valid_nxt = 1'b1;
                    instr_nxt     = enc_word;
                    err_nxt       = enc_err;
                    last_nxt      = !enc_two;
                    if (enc_two) begin
                        state_nxt = SECOND;
                        pend_nxt  = li_addi_rd;
                    end
                end else if (out_ready) begin
                    out_valid_nxt = 1'b0;
                end
            end
            SECOND: begin
                if (out_ready) begin
                    instr_nxt = pend_q;
                    err_nxt   = 1'b0;
                    last_nxt  = 1'b1;
                    state_nxt = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            pend_q    <= 32'd0;
            out_valid <= 1'b0;
            out_instr <= 32'd0;
            out_err   <= 1'b0;
            out_last  <= 1'b0;
        end else begin
            state     <= state_nxt;
            pend_q    <= pend_nxt;
            out_valid <= out_valid_nxt;
            out_instr <= instr_nxt;
            out_err   <= err_nxt;
            out_last  <= last_nxt;
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder with an arithmetic reference model and a per-cycle scoreboard.
module tb_instr_encoder;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  fmt;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic        out_err;
    logic        out_last;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [31:0] instr;
        logic        err;
        logic        last;
    } beat_t;

    beat_t exp_q[$];

    instr_encoder dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .fmt(fmt), .opcode(opcode), .funct3(funct3),
        .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_err(out_err), .out_last(out_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference encoding from the field rules using plain arithmetic on integers.
    function automatic void model(input logic [2:0] f, input logic [6:0] op, input logic [2:0] f3,
                                  input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2,
                                  input logic [31:0] im, output beat_t b0, output beat_t b1, output int n);
        longint s;
        logic [31:0] w, hi, lo;
        logic e;
        s = longint'($signed(im));
        n = 1; w = 32'd0; e = 1'b0; b1 = '0;
        case (f)
            3'd0: begin
                w = ((im & 32'hFFF) << 20) | (32'(s1) << 15) | (32'(f3) << 12) | (32'(d) << 7) | 32'(op);
                e = (s < -2048) || (s > 2047);
            end
            3'd1: begin
                w = (((im >> 5) & 32'h7F) << 25) | (32'(s2) << 20) | (32'(s1) << 15) | (32'(f3) << 12)
                    | ((im & 32'h1F) << 7) | 32'(op);
                e = (s < -2048) || (s > 2047);
            end
            3'd2: begin
                w = (((im >> 12) & 32'h1) << 31) | (((im >> 5) & 32'h3F) << 25) | (32'(s2) << 20)
                    | (32'(s1) << 15) | (32'(f3) << 12) | (((im >> 1) & 32'hF) << 8)
                    | (((im >> 11) & 32'h1) << 7) | 32'(op);
                e = (s < -4096) || (s > 4095) || (s % 2 != 0);
            end
            3'd3: begin
                w = (im & 32'hFFFFF000) | (32'(d) << 7) | 32'(op);
                e = (im % 4096) != 0;
            end
            3'd4: begin
                w = (((im >> 20) & 32'h1) << 31) | (((im >> 1) & 32'h3FF) << 21) | (((im >> 11) & 32'h1) << 20)
                    | (((im >> 12) & 32'hFF) << 12) | (32'(d) << 7) | 32'(op);
                e = (s < -1048576) || (s > 1048575) || (s % 2 != 0);
            end
            3'd5: begin
                lo = im & 32'hFFF;
                hi = (im + 32'h800) >> 12;
                if (hi == 0) begin
                    w = (lo << 20) | (32'(d) << 7) | 32'h13;
                end else if (lo == 0) begin
                    w = (hi << 12) | (32'(d) << 7) | 32'h37;
                end else begin
                    w = (hi << 12) | (32'(d) << 7) | 32'h37;
                    n = 2;
                    b1.instr = (lo << 20) | (32'(d) << 15) | (32'(d) << 7) | 32'h13;
                    b1.err   = 1'b0;
                    b1.last  = 1'b1;
                end
            end
            default: begin
                w = 32'd0;
                e = 1'b1;
            end
        endcase
        b0.instr = w;
        b0.err   = e;
        b0.last  = (n == 1);
    endfunction

    // Scoreboard: checks every cycle against the queued model beats.
    always @(negedge clk) begin
        beat_t b0, b1;
        int n;
        if (!rst_n) begin
            chk("rst_out_valid", 32'(out_valid), 32'd0);
            chk("rst_out_instr", out_instr, 32'd0);
            chk("rst_out_err", 32'(out_err), 32'd0);
            chk("rst_out_last", 32'(out_last), 32'd0);
            chk("rst_in_ready", 32'(in_ready), 32'd0);
            exp_q.delete();
        end else begin
            chk("sb_out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
            chk("sb_in_ready", 32'(in_ready),
                32'((exp_q.size() == 0) || (exp_q.size() == 1 && out_ready)));
            if (out_valid && exp_q.size() != 0) begin
                chk("sb_instr", out_instr, exp_q[0].instr);
                chk("sb_err", 32'(out_err), 32'(exp_q[0].err));
                chk("sb_last", 32'(out_last), 32'(exp_q[0].last));
                if (out_ready) void'(exp_q.pop_front());
            end
            if (in_valid && in_ready) begin
                model(fmt, opcode, funct3, rd, rs1, rs2, imm, b0, b1, n);
                exp_q.push_back(b0);
                if (n == 2) exp_q.push_back(b1);
            end
        end
    end

    task automatic send(input logic [2:0] f, input logic [6:0] op, input logic [2:0] f3,
                        input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2, input logic [31:0] im);
        bit ok;
        int n;
        fmt = f; opcode = op; funct3 = f3; rd = d; rs1 = s1; rs2 = s2; imm = im;
        in_valid = 1'b1;
        n = 0;
        ok = 1'b0;
        do begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!ok && n < 50);
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: in_ready never seen after %0d cycles", n);
        end
        in_valid = 1'b0;
    endtask

    task automatic expect_now(input string tag, input logic [31:0] instr, input logic err, input logic last);
        chk({tag, "_valid"}, 32'(out_valid), 32'd1);
        chk({tag, "_instr"}, out_instr, instr);
        chk({tag, "_err"}, 32'(out_err), 32'(err));
        chk({tag, "_last"}, 32'(out_last), 32'(last));
    endtask

    task automatic pin(input string tag, input logic [2:0] f, input logic [6:0] op, input logic [2:0] f3,
                       input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2, input logic [31:0] im,
                       input int en, input logic [31:0] e0, input logic ee, input logic [31:0] e1);
        beat_t b0, b1;
        int n;
        model(f, op, f3, d, s1, s2, im, b0, b1, n);
        chk({tag, "_model_n"}, 32'(n), 32'(en));
        chk({tag, "_model_w0"}, b0.instr, e0);
        chk({tag, "_model_err"}, 32'(b0.err), 32'(ee));
        if (en == 2) chk({tag, "_model_w1"}, b1.instr, e1);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        fmt = 3'd0; opcode = 7'd0; funct3 = 3'd0; rd = 5'd0; rs1 = 5'd0; rs2 = 5'd0; imm = 32'd0;

        pin("m_i",   3'd0, 7'h13, 3'd0, 5'd1, 5'd0, 5'd0, 32'd5,        1, 32'h00500093, 1'b0, 32'd0);
        pin("m_s",   3'd1, 7'h23, 3'd2, 5'd0, 5'd3, 5'd2, 32'd8,        1, 32'h0021A423, 1'b0, 32'd0);
        pin("m_b",   3'd2, 7'h63, 3'd0, 5'd0, 5'd0, 5'd0, 32'hFFFFFFFC, 1, 32'hFE000EE3, 1'b0, 32'd0);
        pin("m_li2", 3'd5, 7'h00, 3'd0, 5'd5, 5'd0, 5'd0, 32'h12345FFF, 2, 32'h123462B7, 1'b0, 32'hFFF28293);
        pin("m_ierr",3'd0, 7'h13, 3'd0, 5'd1, 5'd0, 5'd0, 32'd2048,     1, 32'h80000093, 1'b1, 32'd0);
        pin("m_j",   3'd4, 7'h6F, 3'd0, 5'd1, 5'd0, 5'd0, 32'd8,        1, 32'h008000EF, 1'b0, 32'd0);

        repeat (2) @(negedge clk);
        tick();
        rst_n = 1'b1;
        #1;
        chk("release_in_ready", 32'(in_ready), 32'd1);
        chk("release_out_valid", 32'(out_valid), 32'd0);

        send(3'd0, 7'h13, 3'd0, 5'd1, 5'd0, 5'd0, 32'd5);
        expect_now("i_basic", 32'h00500093, 1'b0, 1'b1);
        send(3'd1, 7'h23, 3'd2, 5'd0, 5'd3, 5'd2, 32'd8);
        expect_now("s_basic", 32'h0021A423, 1'b0, 1'b1);
        send(3'd2, 7'h63, 3'd0, 5'd0, 5'd0, 5'd0, 32'hFFFFFFFC);
        expect_now("b_neg4", 32'hFE000EE3, 1'b0, 1'b1);
        send(3'd5, 7'h00, 3'd0, 5'd5, 5'd0, 5'd0, 32'h12345FFF);
        expect_now("li_b1", 32'h123462B7, 1'b0, 1'b0);
        chk("li_between_in_ready", 32'(in_ready), 32'd0);
        tick();
        expect_now("li_b2", 32'hFFF28293, 1'b0, 1'b1);
        send(3'd5, 7'h00, 3'd0, 5'd5, 5'd0, 5'd0, 32'hFFFFF800);
        expect_now("li_neg", 32'h80000293, 1'b0, 1'b1);
        send(3'd5, 7'h00, 3'd0, 5'd5, 5'd0, 5'd0, 32'h00001000);
        expect_now("li_lui", 32'h000012B7, 1'b0, 1'b1);
        send(3'd5, 7'h00, 3'd0, 5'd5, 5'd0, 5'd0, 32'd0);
        expect_now("li_zero", 32'h00000293, 1'b0, 1'b1);
        send(3'd0, 7'h13, 3'd0, 5'd1, 5'd0, 5'd0, 32'd2048);
        expect_now("i_range", 32'h80000093, 1'b1, 1'b1);
        send(3'd2, 7'h63, 3'd0, 5'd0, 5'd0, 5'd0, 32'd3);
        expect_now("b_odd", 32'h00000163, 1'b1, 1'b1);
        send(3'd7, 7'h13, 3'd1, 5'd1, 5'd2, 5'd3, 32'd4);
        expect_now("fmt7", 32'd0, 1'b1, 1'b1);
        send(3'd3, 7'h37, 3'd0, 5'd2, 5'd0, 5'd0, 32'h12345000);
        expect_now("u_ok", 32'h12345137, 1'b0, 1'b1);
        send(3'd3, 7'h37, 3'd0, 5'd2, 5'd0, 5'd0, 32'h12345001);
        expect_now("u_err", 32'h12345137, 1'b1, 1'b1);
        send(3'd4, 7'h6F, 3'd0, 5'd1, 5'd0, 5'd0, 32'd8);
        expect_now("j_ok", 32'h008000EF, 1'b0, 1'b1);

        repeat (3) tick();
        out_ready = 1'b0;
        send(3'd0, 7'h13, 3'd0, 5'd1, 5'd0, 5'd0, 32'd5);
        expect_now("bp_first", 32'h00500093, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            tick();
            expect_now("bp_hold", 32'h00500093, 1'b0, 1'b1);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        tick();
        chk("bp_drained", 32'(out_valid), 32'd0);

        out_ready = 1'b0;
        send(3'd5, 7'h00, 3'd0, 5'd5, 5'd0, 5'd0, 32'h12345FFF);
        expect_now("rst_li_b1", 32'h123462B7, 1'b0, 1'b0);
        tick();
        chk("rst_li_in_ready", 32'(in_ready), 32'd0);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_instr", out_instr, 32'd0);
        chk("mid_rst_last", 32'(out_last), 32'd0);
        chk("mid_rst_in_ready", 32'(in_ready), 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        out_ready = 1'b1;
        send(3'd5, 7'h00, 3'd0, 5'd5, 5'd0, 5'd0, 32'h12345FFF);
        expect_now("post_rst_b1", 32'h123462B7, 1'b0, 1'b0);
        tick();
        expect_now("post_rst_b2", 32'hFFF28293, 1'b0, 1'b1);

        n = 0;
        while (exp_q.size() != 0 && n < 20) begin
            tick();
            n++;
        end
        chk("drain_queue", 32'(exp_q.size()), 32'd0);
        tick();
        chk("final_out_valid", 32'(out_valid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
